// File: rtl/pcie_probe_pkg.sv
// pcie_probe_pkg
//   Shared types and default parameters for the PCIe read-latency probe.
//   tag_t / ts_t are sized by the default widths. sample_t bundles one
//   latency sample for consumers that move samples around as a single word.
package pcie_probe_pkg;

   localparam int TAG_W_DEF       = 5;
   localparam int TS_W_DEF        = 32;
   localparam int TIMEOUT_CYC_DEF = 65536;

   typedef logic [TAG_W_DEF-1:0] tag_t;
   typedef logic [TS_W_DEF-1:0]  ts_t;

   typedef struct packed {
      tag_t tag;
      ts_t  lat;
   } sample_t;

endpackage

// File: rtl/pcie_probe_ts_regfile.sv
// pcie_probe_ts_regfile
//   Request timestamp table: 2**TAG_W entries of TS_W bits.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     we/waddr/wdata    write port (request stamping)
//     raddr_a/rdata_a   asynchronous read port (completion lookup)
//     raddr_b/rdata_b   asynchronous read port (timeout scanner)
module pcie_probe_ts_regfile
   import pcie_probe_pkg::*;
#(
   parameter int TAG_W = TAG_W_DEF,
   parameter int TS_W  = TS_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [TAG_W-1:0] waddr,
   input  logic [TS_W-1:0]  wdata,
   input  logic [TAG_W-1:0] raddr_a,
   output logic [TS_W-1:0]  rdata_a,
   input  logic [TAG_W-1:0] raddr_b,
   output logic [TS_W-1:0]  rdata_b
);

   localparam int DEPTH = 1 << TAG_W;

   logic [TS_W-1:0] mem_r [DEPTH];

   // Timestamp storage; cleared on reset so reads never see X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {TS_W{1'b0}};
         end
      end else if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata_a = mem_r[raddr_a];
   assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/pcie_rd_lat_probe.sv
// pcie_rd_lat_probe
//   Measures read latency per tag: stamps requests, matches the last
//   completion beat of the tag, and emits one latency sample. A scanner
//   visits one tag per clock and retires tags pending too long as timeouts.
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     clr                             sync clear of pending tags and count
//     req_valid, req_tag              issued read request
//     cpl_valid, cpl_last, cpl_tag    accepted completion beat
//     sample_valid/lat/tag            registered latency sample pulse
//     timeout_valid/tag               registered timeout retire pulse
//     err_dup_tag, err_orphan         registered error pulses
//     outstanding                     registered pending-tag count
module pcie_rd_lat_probe
   import pcie_probe_pkg::*;
#(
   parameter int TAG_W       = TAG_W_DEF,
   parameter int TS_W        = TS_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             req_valid,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             cpl_valid,
   input  logic             cpl_last,
   input  logic [TAG_W-1:0] cpl_tag,
   output logic             sample_valid,
   output logic [TS_W-1:0]  sample_lat,
   output logic [TAG_W-1:0] sample_tag,
   output logic             timeout_valid,
   output logic [TAG_W-1:0] timeout_tag,
   output logic             err_dup_tag,
   output logic             err_orphan,
   output logic [TAG_W:0]   outstanding
);

   localparam int              DEPTH      = 1 << TAG_W;
   localparam logic [TS_W-1:0] TIMEOUT_TS = TS_W'(TIMEOUT_CYC);
   localparam logic [TS_W-1:0] TS_ONE     = {{(TS_W-1){1'b0}}, 1'b1};
   localparam logic [TAG_W-1:0] TAG_ONE   = {{(TAG_W-1){1'b0}}, 1'b1};
   localparam logic [DEPTH-1:0] BIT0      = {{(DEPTH-1){1'b0}}, 1'b1};
   localparam logic [TAG_W:0]  CNT_ZERO   = {(TAG_W+1){1'b0}};

   logic [TS_W-1:0]  now_r;
   logic [TAG_W-1:0] scan_ptr_r;
   logic [DEPTH-1:0] pending_r;

   logic [TS_W-1:0]  ts_cpl_s;
   logic [TS_W-1:0]  ts_scan_s;
   logic [TS_W-1:0]  lat_s;
   logic [TS_W-1:0]  age_s;
   logic             cpl_hit_s;
   logic             do_sample_s;
   logic             do_orphan_s;
   logic             new_req_s;
   logic             do_dup_s;
   logic             scan_hit_s;
   logic [DEPTH-1:0] sample_mask_s;
   logic [DEPTH-1:0] scan_mask_s;
   logic [DEPTH-1:0] req_mask_s;
   logic [DEPTH-1:0] pending_nxt_s;
   logic [TAG_W:0]   out_nxt_s;

   pcie_probe_ts_regfile #(
      .TAG_W (TAG_W),
      .TS_W  (TS_W)
   ) u_ts (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (req_valid & ~clr),
      .waddr   (req_tag),
      .wdata   (now_r),
      .raddr_a (cpl_tag),
      .rdata_a (ts_cpl_s),
      .raddr_b (scan_ptr_r),
      .rdata_b (ts_scan_s)
   );

   assign cpl_hit_s   = cpl_valid & cpl_last;
   assign do_sample_s = cpl_hit_s & pending_r[cpl_tag];
   assign do_orphan_s = cpl_hit_s & ~pending_r[cpl_tag];
   // A same-cycle last completion frees the tag first, so the request re-arms it as new.
   assign new_req_s   = req_valid & (~pending_r[req_tag] | (do_sample_s & (cpl_tag == req_tag)));
   assign do_dup_s    = req_valid & ~new_req_s;

   // Modular subtraction keeps latency and age correct across timestamp wrap.
   assign lat_s = now_r - ts_cpl_s;
   assign age_s = now_r - ts_scan_s;

   // Retire deferred to the next pass when the scanned tag is touched this cycle.
   assign scan_hit_s = pending_r[scan_ptr_r] & (age_s >= TIMEOUT_TS)
                     & ~(req_valid & (req_tag == scan_ptr_r))
                     & ~(cpl_hit_s & (cpl_tag == scan_ptr_r));

   assign sample_mask_s = do_sample_s ? (BIT0 << cpl_tag)    : {DEPTH{1'b0}};
   assign scan_mask_s   = scan_hit_s  ? (BIT0 << scan_ptr_r) : {DEPTH{1'b0}};
   assign req_mask_s    = req_valid   ? (BIT0 << req_tag)    : {DEPTH{1'b0}};
   assign pending_nxt_s = (pending_r & ~sample_mask_s & ~scan_mask_s) | req_mask_s;

   assign out_nxt_s = outstanding + {{TAG_W{1'b0}}, new_req_s}
                                  - {{TAG_W{1'b0}}, do_sample_s}
                                  - {{TAG_W{1'b0}}, scan_hit_s};

   // Timestamp, scanner, pending bitmap, count and registered output pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         now_r         <= {TS_W{1'b0}};
         scan_ptr_r    <= {TAG_W{1'b0}};
         pending_r     <= {DEPTH{1'b0}};
         outstanding   <= CNT_ZERO;
         sample_valid  <= 1'b0;
         sample_lat    <= {TS_W{1'b0}};
         sample_tag    <= {TAG_W{1'b0}};
         timeout_valid <= 1'b0;
         timeout_tag   <= {TAG_W{1'b0}};
         err_dup_tag   <= 1'b0;
         err_orphan    <= 1'b0;
      end else begin
         now_r      <= now_r + TS_ONE;
         scan_ptr_r <= scan_ptr_r + TAG_ONE;
         if (clr) begin
            pending_r     <= {DEPTH{1'b0}};
            outstanding   <= CNT_ZERO;
            sample_valid  <= 1'b0;
            timeout_valid <= 1'b0;
            err_dup_tag   <= 1'b0;
            err_orphan    <= 1'b0;
         end else begin
            pending_r     <= pending_nxt_s;
            outstanding   <= out_nxt_s;
            sample_valid  <= do_sample_s;
            timeout_valid <= scan_hit_s;
            err_dup_tag   <= do_dup_s;
            err_orphan    <= do_orphan_s;
            if (do_sample_s) begin
               sample_lat <= lat_s;
               sample_tag <= cpl_tag;
            end
            if (scan_hit_s) begin
               timeout_tag <= scan_ptr_r;
            end
         end
      end
   end

endmodule

// File: tb/tb_pcie_rd_lat_probe.sv
// tb_pcie_rd_lat_probe
//   Directed scenarios plus randomized traffic checked against a per-tag
//   reference model of pending flags and request cycles. The DUT is built
//   with an 8-bit timestamp and a 100-clock timeout so wrap and timeout
//   behaviour is reachable quickly.
module tb_pcie_rd_lat_probe;

   localparam int TAG_W = 5;
   localparam int TS_W  = 8;
   localparam int TO    = 100;
   localparam int NTAG  = 32;
   localparam int TSMOD = 256;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clr;
   logic             req_valid;
   logic [TAG_W-1:0] req_tag;
   logic             cpl_valid;
   logic             cpl_last;
   logic [TAG_W-1:0] cpl_tag;
   logic             sample_valid;
   logic [TS_W-1:0]  sample_lat;
   logic [TAG_W-1:0] sample_tag;
   logic             timeout_valid;
   logic [TAG_W-1:0] timeout_tag;
   logic             err_dup_tag;
   logic             err_orphan;
   logic [TAG_W:0]   outstanding;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int  cyc;
   int  m_ts   [NTAG];
   bit  m_pend [NTAG];
   int  m_out;
   bit  e_sv, e_tv, e_dup, e_orph;
   int  e_lat, e_stag, e_ttag;

   pcie_rd_lat_probe #(
      .TAG_W       (TAG_W),
      .TS_W        (TS_W),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clr           (clr),
      .req_valid     (req_valid),
      .req_tag       (req_tag),
      .cpl_valid     (cpl_valid),
      .cpl_last      (cpl_last),
      .cpl_tag       (cpl_tag),
      .sample_valid  (sample_valid),
      .sample_lat    (sample_lat),
      .sample_tag    (sample_tag),
      .timeout_valid (timeout_valid),
      .timeout_tag   (timeout_tag),
      .err_dup_tag   (err_dup_tag),
      .err_orphan    (err_orphan),
      .outstanding   (outstanding)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      cyc = 0;
      m_out = 0;
      for (int i = 0; i < NTAG; i++) begin
         m_pend[i] = 1'b0;
         m_ts[i]   = 0;
      end
      e_sv = 0; e_tv = 0; e_dup = 0; e_orph = 0;
      e_lat = 0; e_stag = 0; e_ttag = 0;
   endtask

   // One clock: the model consumes the inputs present at the edge, then outputs settle.
   task automatic tick();
      bit hit, smp, orph, newr, tmo;
      int sp, ct, rt;
      @(posedge clk);
      sp = cyc % NTAG;
      ct = int'(cpl_tag);
      rt = int'(req_tag);
      if (clr) begin
         for (int i = 0; i < NTAG; i++) m_pend[i] = 1'b0;
         m_out = 0;
         e_sv = 0; e_tv = 0; e_dup = 0; e_orph = 0;
      end else begin
         hit  = cpl_valid && cpl_last;
         smp  = hit && m_pend[ct];
         orph = hit && !m_pend[ct];
         newr = req_valid && (!m_pend[rt] || (smp && ct == rt));
         tmo  = m_pend[sp] && !(req_valid && rt == sp) && !(hit && ct == sp)
                && (((cyc - m_ts[sp]) % TSMOD) >= TO);
         e_sv = smp; e_orph = orph; e_dup = req_valid && !newr; e_tv = tmo;
         if (smp) begin
            e_lat  = (cyc - m_ts[ct]) % TSMOD;
            e_stag = ct;
         end
         if (tmo) e_ttag = sp;
         if (smp) m_pend[ct] = 1'b0;
         if (tmo) m_pend[sp] = 1'b0;
         if (req_valid) begin
            m_pend[rt] = 1'b1;
            m_ts[rt]   = cyc;
         end
         m_out = m_out + int'(newr) - int'(smp) - int'(tmo);
      end
      cyc++;
      #1;
   endtask

   task automatic drive(input bit rv, input int rt, input bit cv, input bit cl, input int ct);
      req_valid = rv;
      req_tag   = rt[TAG_W-1:0];
      cpl_valid = cv;
      cpl_last  = cl;
      cpl_tag   = ct[TAG_W-1:0];
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 0, 0);
      clr = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      n_tests++;
      if (outstanding !== 6'd0 || sample_valid !== 1'b0 || timeout_valid !== 1'b0 ||
          err_dup_tag !== 1'b0 || err_orphan !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: out=%0d sv=%0b tv=%0b dup=%0b orph=%0b expected all 0",
                  outstanding, sample_valid, timeout_valid, err_dup_tag, err_orphan);
      end
   endtask

   task automatic test_basic();
      drive(1, 3, 0, 0, 0); tick();
      n_tests++;
      if (outstanding !== 6'd1) begin n_fail++; $display("FAIL basic_out1: got %0d expected 1", outstanding); end
      idle(41);
      drive(0, 0, 1, 1, 3); tick();
      n_tests++;
      if (sample_valid !== 1'b1 || sample_lat !== 8'd42 || sample_tag !== 5'd3) begin
         n_fail++;
         $display("FAIL basic_sample: sv=%0b lat=%0d tag=%0d expected 1/42/3", sample_valid, sample_lat, sample_tag);
      end
      n_tests++;
      if (outstanding !== 6'd0) begin n_fail++; $display("FAIL basic_out0: got %0d expected 0", outstanding); end
      idle(1);
   endtask

   task automatic test_nonlast();
      drive(1, 3, 0, 0, 0); tick();
      idle(9);
      drive(0, 0, 1, 0, 3); tick();
      n_tests++;
      if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL nonlast_nosample: sv=%0b expected 0", sample_valid); end
      idle(9);
      drive(0, 0, 1, 1, 3); tick();
      n_tests++;
      if (sample_valid !== 1'b1 || sample_lat !== 8'd20) begin
         n_fail++;
         $display("FAIL nonlast_sample: sv=%0b lat=%0d expected 1/20", sample_valid, sample_lat);
      end
      idle(1);
      n_tests++;
      if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL nonlast_single: sv=%0b expected 0", sample_valid); end
   endtask

   task automatic test_timeout();
      int  k;
      bit  seen;
      drive(1, 7, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      seen = 0;
      k = 0;
      while (!seen && k < 200) begin
         tick();
         k++;
         if (timeout_valid === 1'b1) seen = 1;
      end
      n_tests++;
      if (!seen || timeout_tag !== 5'd7 || k < 100 || k > 133) begin
         n_fail++;
         $display("FAIL timeout_detect: seen=%0b tag=%0d after=%0d expected tag 7 within 100..133", seen, timeout_tag, k);
      end
      n_tests++;
      if (outstanding !== 6'd0) begin n_fail++; $display("FAIL timeout_out: got %0d expected 0", outstanding); end
      idle(3);
      drive(0, 0, 1, 1, 7); tick();
      n_tests++;
      if (err_orphan !== 1'b1 || sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_orphan: orph=%0b sv=%0b expected 1/0", err_orphan, sample_valid);
      end
      idle(1);
   endtask

   task automatic test_dup();
      drive(1, 5, 0, 0, 0); tick();
      idle(7);
      drive(1, 5, 0, 0, 0); tick();
      n_tests++;
      if (err_dup_tag !== 1'b1 || outstanding !== 6'd1) begin
         n_fail++;
         $display("FAIL dup_flag: dup=%0b out=%0d expected 1/1", err_dup_tag, outstanding);
      end
      idle(11);
      drive(0, 0, 1, 1, 5); tick();
      n_tests++;
      if (sample_valid !== 1'b1 || sample_lat !== 8'd12 || outstanding !== 6'd0) begin
         n_fail++;
         $display("FAIL dup_sample: sv=%0b lat=%0d out=%0d expected 1/12/0", sample_valid, sample_lat, outstanding);
      end
      idle(1);
   endtask

   task automatic test_back_to_back();
      drive(1, 2, 0, 0, 0); tick();
      idle(5);
      drive(1, 2, 1, 1, 2); tick();
      n_tests++;
      if (sample_valid !== 1'b1 || sample_lat !== 8'd6 || sample_tag !== 5'd2 ||
          outstanding !== 6'd1 || err_dup_tag !== 1'b0) begin
         n_fail++;
         $display("FAIL same_cycle: sv=%0b lat=%0d tag=%0d out=%0d dup=%0b expected 1/6/2/1/0",
                  sample_valid, sample_lat, sample_tag, outstanding, err_dup_tag);
      end
      idle(3);
      drive(0, 0, 1, 1, 2); tick();
      n_tests++;
      if (sample_valid !== 1'b1 || sample_lat !== 8'd4 || outstanding !== 6'd0) begin
         n_fail++;
         $display("FAIL same_cycle_rearm: sv=%0b lat=%0d out=%0d expected 1/4/0", sample_valid, sample_lat, outstanding);
      end
      idle(1);
   endtask

   task automatic test_wrap();
      drive(0, 0, 0, 0, 0);
      while (cyc % TSMOD != 240) tick();
      drive(1, 9, 0, 0, 0); tick();
      idle(31);
      drive(0, 0, 1, 1, 9); tick();
      n_tests++;
      if (sample_valid !== 1'b1 || sample_lat !== 8'h20 || sample_tag !== 5'd9) begin
         n_fail++;
         $display("FAIL wrap_lat: sv=%0b lat=%0h tag=%0d expected 1/20/9", sample_valid, sample_lat, sample_tag);
      end
      idle(1);
   endtask

   task automatic test_clr();
      for (int t = 0; t < 4; t++) begin
         drive(1, t, 0, 0, 0); tick();
      end
      n_tests++;
      if (outstanding !== 6'd4) begin n_fail++; $display("FAIL clr_pre: got %0d expected 4", outstanding); end
      clr = 1'b1;
      drive(1, 10, 1, 1, 0); tick();
      clr = 1'b0;
      n_tests++;
      if (outstanding !== 6'd0 || sample_valid !== 1'b0 || err_orphan !== 1'b0 || err_dup_tag !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_cycle: out=%0d sv=%0b orph=%0b dup=%0b expected 0/0/0/0",
                  outstanding, sample_valid, err_orphan, err_dup_tag);
      end
      drive(0, 0, 1, 1, 1); tick();
      n_tests++;
      if (err_orphan !== 1'b1 || sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_dropped: orph=%0b sv=%0b expected 1/0", err_orphan, sample_valid);
      end
      drive(0, 0, 1, 1, 10); tick();
      n_tests++;
      if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL clr_req_ignored: orph=%0b expected 1", err_orphan); end
      idle(1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         clr = ($urandom_range(0, 99) < 1) ? 1'b1 : 1'b0;
         drive(($urandom_range(0, 99) < 25), $urandom_range(0, 7),
               ($urandom_range(0, 99) < 40), ($urandom_range(0, 1) == 1), $urandom_range(0, 7));
         tick();
         n_tests++;
         if (sample_valid !== e_sv || (e_sv && (sample_lat !== e_lat[TS_W-1:0] || sample_tag !== e_stag[TAG_W-1:0]))) begin
            n_fail++;
            $display("FAIL rand_sample@%0d: sv=%0b lat=%0d tag=%0d expected %0b/%0d/%0d",
                     cyc, sample_valid, sample_lat, sample_tag, e_sv, e_lat, e_stag);
         end
         n_tests++;
         if (timeout_valid !== e_tv || (e_tv && timeout_tag !== e_ttag[TAG_W-1:0])) begin
            n_fail++;
            $display("FAIL rand_timeout@%0d: tv=%0b tag=%0d expected %0b/%0d", cyc, timeout_valid, timeout_tag, e_tv, e_ttag);
         end
         n_tests++;
         if (err_dup_tag !== e_dup || err_orphan !== e_orph) begin
            n_fail++;
            $display("FAIL rand_err@%0d: dup=%0b orph=%0b expected %0b/%0b", cyc, err_dup_tag, err_orphan, e_dup, e_orph);
         end
         n_tests++;
         if (outstanding !== m_out[TAG_W:0]) begin
            n_fail++;
            $display("FAIL rand_out@%0d: got %0d expected %0d", cyc, outstanding, m_out);
         end
      end
      drive(0, 0, 0, 0, 0);
      clr = 1'b0;
   endtask

   task automatic test_mid_reset();
      drive(1, 12, 0, 0, 0); tick();
      drive(1, 13, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (outstanding !== 6'd0 || sample_valid !== 1'b0 || timeout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: out=%0d sv=%0b tv=%0b expected 0/0/0", outstanding, sample_valid, timeout_valid);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      drive(0, 0, 1, 1, 12); tick();
      n_tests++;
      if (err_orphan !== 1'b1 || sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_orphan: orph=%0b sv=%0b expected 1/0", err_orphan, sample_valid);
      end
      idle(1);
   endtask

   initial begin
      rst_n = 1'b0;
      clr   = 1'b0;
      drive(0, 0, 0, 0, 0);
      model_reset();
      #12;
      test_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      test_basic();
      test_nonlast();
      test_timeout();
      test_dup();
      test_back_to_back();
      test_wrap();
      test_clr();
      test_random();
      clr = 1'b1; tick(); clr = 1'b0;
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
